// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES byte tables, GF(2^8) helpers and round transforms shared by encrypt and decrypt.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} aes_fsm_t;

  // Tables are indexed directly by byte value: element 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  // Byte 4c+r sits in row r of column c; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_if.sv
// rtl/aes_inv_cipher_if.sv - ciphertext-in / plaintext-out valid/ready handshake bundle.
interface aes_inv_cipher_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct;
  logic [127:0] pt;
  logic         out_valid;
  logic         out_ready;

  modport master (output in_valid, ct, out_ready, input in_ready, pt, out_valid);
  modport slave  (input in_valid, ct, out_ready, output in_ready, pt, out_valid);
endinterface

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - combinational single inverse round; last=1 skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic         last,
  output logic [127:0] next_state
);

  logic [127:0] keyed;

  assign keyed      = add_round_key(inv_sub_bytes(inv_shift_rows(state)), key);
  assign next_state = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_inv_cipher.sv
// rtl/aes_inv_cipher.sv - iterative AES inverse cipher, one round per clock.
// Optional AES_INV_ZEROIZE_EN clears the state register and masks pt outside DONE.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter  int Nk = 4,
  localparam int Nr = Nk + 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] k_sch [0:Nr],
  aes_inv_cipher_if.slave bus
);

  aes_fsm_t     fsm, fsm_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [127:0] state_q, state_nxt, round_out;
  logic         idle_c, done_c;

  // The schedule is read live each RUN cycle, so it must hold until out_valid.
  aes_inv_round u_round (
    .state      (state_q),
    .key        (k_sch[rnd]),
    .last       (rnd == 4'd0),
    .next_state (round_out)
  );

  always_comb begin
    fsm_nxt   = fsm;
    rnd_nxt   = rnd;
    state_nxt = state_q;
    idle_c    = 1'b0;
    done_c    = 1'b0;
    case (fsm)
      IDLE: begin
        idle_c = 1'b1;
        if (bus.in_valid) begin
          state_nxt = bus.ct ^ k_sch[Nr];
          rnd_nxt   = 4'(Nr - 1);
          fsm_nxt   = RUN;
        end
      end
      RUN: begin
        state_nxt = round_out;
        if (rnd == 4'd0) fsm_nxt = DONE;
        else             rnd_nxt = rnd - 4'd1;
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.out_ready) begin
          fsm_nxt = IDLE;
`ifdef AES_INV_ZEROIZE_EN
          state_nxt = '0;
`endif
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm <= IDLE;
      rnd <= 4'd0;
    end else begin
      fsm <= fsm_nxt;
      rnd <= rnd_nxt;
    end
  end

`ifdef AES_INV_ZEROIZE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= '0;
    else        state_q <= state_nxt;
  end

  assign bus.pt = done_c ? state_q : '0;
`else
  always_ff @(posedge clk) begin
    state_q <= state_nxt;
  end

  assign bus.pt = state_q;
`endif

  assign bus.in_ready  = idle_c & rst_n;
  assign bus.out_valid = done_c;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// tb/tb_aes_inv_cipher.sv - scoreboard bench for aes_inv_cipher at Nk=4/6/8.
module tb_aes_inv_cipher;
  import aes_pkg::SBOX;

  localparam logic [255:0] KEY_SEQ = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_SEQ  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [127:0] ks4 [0:10];
  logic [127:0] ks6 [0:12];
  logic [127:0] ks8 [0:14];
  logic [127:0] rk  [0:14];

  aes_inv_cipher_if if4 ();
  aes_inv_cipher_if if6 ();
  aes_inv_cipher_if if8 ();

  aes_inv_cipher #(.Nk(4)) dut4 (.clk(clk), .rst_n(rst_n), .k_sch(ks4), .bus(if4));
  aes_inv_cipher #(.Nk(6)) dut6 (.clk(clk), .rst_n(rst_n), .k_sch(ks6), .bus(if6));
  aes_inv_cipher #(.Nk(8)) dut8 (.clk(clk), .rst_n(rst_n), .k_sch(ks8), .bus(if8));

  int total = 0;
  int bad   = 0;
  logic started = 1'b0;
  logic [127:0] q4 [$];
  logic [127:0] q6 [$];
  logic [127:0] q8 [$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // FIPS-197 key expansion into rk[0..Nr], built independently of the DUT.
  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < nk + 7; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic in_rdy(input int sel);
    case (sel)
      6:       return if6.in_ready;
      8:       return if8.in_ready;
      default: return if4.in_ready;
    endcase
  endfunction

  function automatic logic o_vld(input int sel);
    case (sel)
      6:       return if6.out_valid;
      8:       return if8.out_valid;
      default: return if4.out_valid;
    endcase
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [127:0] c);
    case (sel)
      6:       begin if6.in_valid = v; if6.ct = c; end
      8:       begin if8.in_valid = v; if8.ct = c; end
      default: begin if4.in_valid = v; if4.ct = c; end
    endcase
  endtask

  task automatic push_exp(input int sel, input logic [127:0] p);
    case (sel)
      6:       q6.push_back(p);
      8:       q8.push_back(p);
      default: q4.push_back(p);
    endcase
  endtask

  // Offer one block, then measure edges from the accept edge to out_valid.
  task automatic send(input int sel, input logic [127:0] c, input logic [127:0] p, input int nr);
    int n;
    int lat;
    n = 0;
    while (!in_rdy(sel) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_ready", 128'(in_rdy(sel)), 128'd1);
    set_in(sel, 1'b1, c);
    push_exp(sel, p);
    @(posedge clk); #1;
    set_in(sel, 1'b0, '0);
    lat = 999;
    for (int k = 0; k < nr + 8; k++) begin
      @(negedge clk);
      if (o_vld(sel)) begin
        lat = k;
        break;
      end
    end
    chk($sformatf("latency_nk%0d", sel), 128'(lat), 128'(nr));
  endtask

  always @(negedge clk) begin
    if (if4.out_valid && if4.out_ready) begin
      if (q4.size() == 0) chk("sb4_unexpected", 128'd1, 128'd0);
      else                chk("pt_nk4", if4.pt, q4.pop_front());
    end
    if (if6.out_valid && if6.out_ready) begin
      if (q6.size() == 0) chk("sb6_unexpected", 128'd1, 128'd0);
      else                chk("pt_nk6", if6.pt, q6.pop_front());
    end
    if (if8.out_valid && if8.out_ready) begin
      if (q8.size() == 0) chk("sb8_unexpected", 128'd1, 128'd0);
      else                chk("pt_nk8", if8.pt, q8.pop_front());
    end
`ifdef AES_INV_ZEROIZE_EN
    if (started && !if4.out_valid) chk("pt_zero_idle", if4.pt, 128'd0);
`endif
  end

  initial begin
    int n;
    logic seen;
    rst_n = 1'b0;
    set_in(4, 1'b0, '0);
    set_in(6, 1'b0, '0);
    set_in(8, 1'b0, '0);
    if4.out_ready = 1'b1;
    if6.out_ready = 1'b1;
    if8.out_ready = 1'b1;
    expand_key(KEY_SEQ, 4); for (int i = 0; i <= 10; i++) ks4[i] = rk[i];
    expand_key(KEY_SEQ, 6); for (int i = 0; i <= 12; i++) ks6[i] = rk[i];
    expand_key(KEY_SEQ, 8); for (int i = 0; i <= 14; i++) ks8[i] = rk[i];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(if4.in_ready), 128'd0);
    chk("rst_out_valid", 128'(if4.out_valid), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    started = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 128'(if4.in_ready), 128'd1);
    chk("idle_out_valid", 128'(if4.out_valid), 128'd0);

    send(4, CT_128, PT_SEQ, 10);
    @(posedge clk); #1;
    expand_key(KEY_B, 4); for (int i = 0; i <= 10; i++) ks4[i] = rk[i];
    send(4, CT_B, PT_B, 10);
    send(6, CT_192, PT_SEQ, 12);
    send(8, CT_256, PT_SEQ, 14);

    // Backpressure: result must hold for 5 cycles while in_ready stays low.
    @(posedge clk); #1;
    expand_key(KEY_SEQ, 4); for (int i = 0; i <= 10; i++) ks4[i] = rk[i];
    if4.out_ready = 1'b0;
    send(4, CT_128, PT_SEQ, 10);
    repeat (5) begin
      chk("bp_out_valid", 128'(if4.out_valid), 128'd1);
      chk("bp_pt_held", if4.pt, PT_SEQ);
      chk("bp_in_ready", 128'(if4.in_ready), 128'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 128'(if4.in_ready), 128'd1);
    chk("bp_release_out_valid", 128'(if4.out_valid), 128'd0);

    // Abort a block with reset while rnd==5; nothing may come out.
    set_in(4, 1'b1, CT_128);
    @(posedge clk); #1;
    set_in(4, 1'b0, '0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rst_in_ready", 128'(if4.in_ready), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 128'(if4.in_ready), 128'd1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (if4.out_valid) seen = 1'b1;
    end
    chk("abort_no_output", 128'(seen), 128'd0);
    send(4, CT_128, PT_SEQ, 10);

    // Input activity during RUN must be ignored.
    @(posedge clk); #1;
    set_in(4, 1'b1, CT_128);
    push_exp(4, PT_SEQ);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      set_in(4, i[0], CT_B ^ 128'(i));
      @(negedge clk);
      chk("run_in_ready", 128'(if4.in_ready), 128'd0);
      @(posedge clk); #1;
    end
    set_in(4, 1'b0, '0);
    n = 0;
    while (!if4.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("toggle_done", 128'(if4.out_valid), 128'd1);

    n = 0;
    while ((q4.size() + q6.size() + q8.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain", 128'(q4.size() + q6.size() + q8.size()), 128'd0);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
